// File: rtl/decoder_3to8_hs.sv
// Handshaked 3-to-8 one-hot decoder with a wrapping output-handshake counter.
// Optional output walk mode (SCAN, port scan_start) is built when DEC_SCAN_EN is defined.
module decoder_3to8_hs (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] a,
   input  logic       en,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] y,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] cnt
`ifdef DEC_SCAN_EN
   ,
   input  logic       scan_start
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HOLD = 2'd1;
`ifdef DEC_SCAN_EN
   localparam logic [1:0] SCAN = 2'd2;
`endif

   logic [1:0] state;
   logic [7:0] load_word;
   logic       in_hs;
   logic       out_hs;

   assign load_word = en ? (8'b1 << a) : 8'h00;
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;

   // A scan request in IDLE takes priority, so the input side is refused that cycle.
   always_comb begin
      in_ready = 1'b0;
      case (state)
`ifdef DEC_SCAN_EN
         IDLE:    in_ready = !scan_start;
`else
         IDLE:    in_ready = 1'b1;
`endif
         HOLD:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         y         <= 8'h00;
         out_valid <= 1'b0;
         cnt       <= 8'h00;
      end else begin
         if (out_hs) begin
            cnt <= cnt + 8'd1;
         end
         case (state)
            IDLE: begin
`ifdef DEC_SCAN_EN
               if (scan_start) begin
                  y         <= 8'h01;
                  out_valid <= 1'b1;
                  state     <= SCAN;
               end else
`endif
               if (in_hs) begin
                  y         <= load_word;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               // in_ready follows out_ready here, so a new capture always retires the old word.
               if (out_hs) begin
                  if (in_hs) begin
                     y <= load_word;
                  end else begin
                     y         <= 8'h00;
                     out_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
`ifdef DEC_SCAN_EN
            SCAN: begin
               if (out_hs) begin
                  if (y == 8'h80) begin
                     y         <= 8'h00;
                     out_valid <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     y <= y << 1;
                  end
               end
            end
`endif
            default: begin
               state     <= IDLE;
               y         <= 8'h00;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
